// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash,
// memory-busy freeze with a watchdog that latches a sticky fault, plus perf counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT  = 64,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       state,
  output logic             fault,
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count
);

  localparam int               WCW   = $clog2(TIMEOUT) + 1;
  localparam logic [WCW-1:0]   WLAST = WCW'(TIMEOUT - 1);
  localparam logic [REG_W-1:0] ZR    = REG_W'(ZERO_REG);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]    stall_cnt_q, stall_cnt_d;
  logic [15:0]    flush_cnt_q, flush_cnt_d;

  logic memstall, loaduse;
  logic [7:0] ctl;  // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, memwb_fl}

  assign memstall = mem_req & ~mem_ready;
  assign loaduse  = ex_mem_read & (ex_rd != ZR) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ctl         = 8'b0000_0000;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (memstall) begin
          ctl         = 8'b0000_1001;
          stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
          if (state_q == RUN) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WCW'(1);
          end else if (wait_cnt_q == WLAST) begin
            state_d = FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          if (ex_branch_taken) begin
            ctl         = 8'b1111_1110;
            flush_cnt_d = (flush_cnt_q == 16'hFFFF) ? flush_cnt_q : flush_cnt_q + 16'd1;
          end else if (loaduse) begin
            ctl         = 8'b0011_1010;
            stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
          end else begin
            ctl = 8'b1111_1000;
          end
        end
      end
      default: ;  // FAULT holds everything frozen until reset
    endcase
    // Reset is asynchronous, so the controls must drop without waiting for an edge.
    if (!reset) ctl = 8'b0000_0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
          ifid_flush, idex_flush, memwb_flush} = ctl;
  assign state       = state_q;
  assign fault       = (state_q == FAULT);
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a reference model pushes expected outputs to a
// scoreboard queue each cycle, which is popped and compared against the DUT.
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush;
  logic [1:0] state;
  logic fault;
  logic [15:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .REG_W(5), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .state(state), .fault(fault),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct packed {
    logic [7:0]  ctl;
    logic [1:0]  st;
    logic        flt;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // reference model state
  int m_state = 0;
  int m_wait  = 0;
  int m_sc    = 0;
  int m_fc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Evaluate one cycle: inputs already driven; compare, then advance model across the edge.
  task automatic cyc(input bit do_chk);
    exp_t e;
    exp_t got;
    bit ms, lu, tk;
    #1;
    ms = mem_req && !mem_ready;
    tk = ex_branch_taken;
    lu = ex_mem_read && (ex_rd != 5'd31) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!reset) begin
      m_state = 0; m_wait = 0; m_sc = 0; m_fc = 0;
    end
    e.st  = m_state[1:0];
    e.flt = (m_state == 2);
    e.sc  = m_sc[15:0];
    e.fc  = m_fc[15:0];
    if (!reset || m_state == 2) e.ctl = 8'b0000_0000;
    else if (ms)                e.ctl = 8'b0000_1001;
    else if (tk)                e.ctl = 8'b1111_1110;
    else if (lu)                e.ctl = 8'b0011_1010;
    else                        e.ctl = 8'b1111_1000;
    sb.push_back(e);

    got = sb.pop_front();
    if (do_chk) begin
      chk("ctl", {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, memwb_flush}, {24'd0, got.ctl});
      chk("state", {30'd0, state}, {30'd0, got.st});
      chk("fault", {31'd0, fault}, {31'd0, got.flt});
      chk("stall_count", {16'd0, stall_count}, {16'd0, got.sc});
      chk("flush_count", {16'd0, flush_count}, {16'd0, got.fc});
    end

    if (reset && m_state != 2) begin
      if (ms) begin
        if (m_sc < 65535) m_sc++;
        if (m_state == 0) begin m_state = 1; m_wait = 1; end
        else if (m_wait >= TIMEOUT - 1) m_state = 2;
        else m_wait++;
      end else begin
        m_state = 0; m_wait = 0;
        if (tk) begin if (m_fc < 65535) m_fc++; end
        else if (lu) begin if (m_sc < 65535) m_sc++; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_loaduse(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = rd; id_uses_rs2 = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #1;
    cyc(1);                              // held in reset
    reset = 1'b1;
    cyc(1);                              // first cycle after release: normal

    set_loaduse(5'd3);
    cyc(1);                              // one bubble
    idle_inputs();
    cyc(1);                              // stall_count = 1, normal
    set_loaduse(5'd31);
    cyc(1);                              // XZR: no hazard
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    cyc(1);                              // rs1 path hazard
    id_uses_rs1 = 1'b0;
    cyc(1);                              // match but source unused
    idle_inputs();

    set_loaduse(5'd3);
    ex_branch_taken = 1'b1;
    cyc(1);                              // taken wins over load-use
    idle_inputs();
    cyc(1);

    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ex_branch_taken = (i == 2);        // ignored under memstall
      cyc(1);
    end
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    cyc(1);                              // release cycle in MEM_WAIT
    idle_inputs();
    cyc(1);

    mem_req = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) cyc(1);
    mem_ready = 1'b1;
    cyc(1);                              // TIMEOUT-1 stalls: no fault
    idle_inputs();
    cyc(1);

    mem_req = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) cyc(1);
    cyc(1);                              // now in FAULT
    mem_ready = 1'b1;
    cyc(1);
    cyc(1);                              // sticky
    reset = 1'b0;
    cyc(1);                              // async clear
    reset = 1'b1;
    idle_inputs();
    cyc(1);

    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1);
    reset = 1'b0;                        // between edges, mid MEM_WAIT
    cyc(1);
    reset = 1'b1;
    idle_inputs();
    cyc(1);

    set_loaduse(5'd4);
    for (int i = 0; i < 65540; i++) cyc(0);
    cyc(1);                              // saturated at FFFF
    cyc(1);
    idle_inputs();
    cyc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
